// File: rtl/ofm_writeback_pkg.sv
// rtl/ofm_writeback_pkg.sv - shared OFM frame geometry and writeback controller state encoding
package ofm_writeback_pkg;

    localparam int DEF_SIZE_POOLING = 13;
    localparam int DEF_NO_FILTER    = 256;

    function automatic int plane_words(input int p);
        return p * p;
    endfunction

    function automatic int frame_words(input int p, input int nf);
        return p * p * nf;
    endfunction

    localparam int OFM_PLANE = plane_words(DEF_SIZE_POOLING);
    localparam int OFM_WORDS = frame_words(DEF_SIZE_POOLING, DEF_NO_FILTER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ofm_writeback_if.sv
// rtl/ofm_writeback_if.sv - pooled-beat input stream and OFM RAM write port
interface ofm_writeback_if
    import ofm_writeback_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int OFM_SIZE_POOLING = DEF_SIZE_POOLING,
    parameter int NO_FILTER        = DEF_NO_FILTER,
    parameter int ADDR_WIDTH       = $clog2(OFM_WORDS)
);
    logic                                    in_valid;
    logic                                    in_ready;
    logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0]   in_data;
    logic [$clog2(SYSTOLIC_SIZE+1)-1:0]      in_count;
    logic [$clog2(NO_FILTER)-1:0]            in_filter;
    logic [$clog2(OFM_SIZE_POOLING)-1:0]     in_row;
    logic [$clog2(OFM_SIZE_POOLING)-1:0]     in_col;
    logic                                    ofm_we;
    logic [ADDR_WIDTH-1:0]                   ofm_addr;
    logic [2*DATA_WIDTH-1:0]                 ofm_wdata;

    modport master (
        output in_valid, in_data, in_count, in_filter, in_row, in_col,
        input  in_ready, ofm_we, ofm_addr, ofm_wdata
    );

    modport slave (
        input  in_valid, in_data, in_count, in_filter, in_row, in_col,
        output in_ready, ofm_we, ofm_addr, ofm_wdata
    );
endinterface

// File: rtl/ofm_addr_gen.sv
// rtl/ofm_addr_gen.sv - filter-major/row-major base address latched at accept plus lane offset
module ofm_addr_gen
    import ofm_writeback_pkg::*;
#(
    parameter int OFM_SIZE_POOLING = DEF_SIZE_POOLING,
    parameter int PLANE            = OFM_PLANE,
    parameter int FW               = 8,
    parameter int RW               = 4,
    parameter int LW               = 4,
    parameter int ADDR_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FW-1:0]         filter,
    input  logic [RW-1:0]         row,
    input  logic [RW-1:0]         col,
    input  logic [LW-1:0]         lane,
    output logic [ADDR_WIDTH-1:0] addr
);
    logic [ADDR_WIDTH-1:0] base_q;

    // Constant-coefficient multiplies only; wraps at ADDR_WIDTH by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else if (load) begin
            base_q <= ADDR_WIDTH'(filter) * ADDR_WIDTH'(PLANE)
                    + ADDR_WIDTH'(row) * ADDR_WIDTH'(OFM_SIZE_POOLING)
                    + ADDR_WIDTH'(col);
        end
    end

    assign addr = base_q + ADDR_WIDTH'(lane);

endmodule

// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - serializes pooled multi-lane beats into single-word OFM RAM writes
module ofm_writeback
    import ofm_writeback_pkg::*;
#(
    parameter int SYSTOLIC_SIZE    = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int OFM_SIZE_POOLING = DEF_SIZE_POOLING,
    parameter int NO_FILTER        = DEF_NO_FILTER,
    parameter int ADDR_WIDTH       = $clog2(OFM_WORDS)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    ofm_writeback_if.slave bus,
    output logic           done_frame,
    output logic           clip_err
);
    localparam int DW2         = 2 * DATA_WIDTH;
    localparam int CW          = $clog2(SYSTOLIC_SIZE + 1);
    localparam int LW          = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int FW          = $clog2(NO_FILTER);
    localparam int RW          = $clog2(OFM_SIZE_POOLING);
    localparam int CNTW        = ADDR_WIDTH + 1;
    localparam int FRAME_WORDS = frame_words(OFM_SIZE_POOLING, NO_FILTER);

    wb_state_e                   state_q, state_d;
    logic [LW-1:0]               lane_q, lane_d;
    logic [CW-1:0]               n_q, n_d, n_eff;
    logic [CNTW-1:0]             word_cnt, word_cnt_d;
    logic [SYSTOLIC_SIZE*DW2-1:0] data_q;
    logic                        clip_d, done_d, beat_clip, last_lane, accept, load;
    int                          req, avail, eff;

    assign last_lane    = (state_q == WRITE) && (int'(lane_q) == int'(n_q) - 1);
    assign bus.in_ready = rst_n && !start && ((state_q == IDLE) || last_lane);
    assign accept       = bus.in_valid && bus.in_ready;

    // Lanes past the right edge of the pooled row, or beats with bad tags, are dropped.
    always_comb begin
        req   = (int'(bus.in_count) < SYSTOLIC_SIZE) ? int'(bus.in_count) : SYSTOLIC_SIZE;
        avail = (int'(bus.in_col) >= OFM_SIZE_POOLING) ? 0 : OFM_SIZE_POOLING - int'(bus.in_col);
        eff   = (req < avail) ? req : avail;
        beat_clip = (eff < req);
        if ((int'(bus.in_filter) >= NO_FILTER) || (int'(bus.in_row) >= OFM_SIZE_POOLING)) begin
            eff       = 0;
            beat_clip = 1'b1;
        end
        n_eff = CW'(eff);
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        n_d        = n_q;
        word_cnt_d = word_cnt;
        clip_d     = clip_err;
        load       = 1'b0;
        if (start) begin
            state_d    = IDLE;
            lane_d     = '0;
            word_cnt_d = '0;
            clip_d     = 1'b0;
        end else begin
            if (state_q == WRITE) begin
                word_cnt_d = word_cnt + 1'b1;
                if (!last_lane)
                    lane_d = lane_q + 1'b1;
                else if (word_cnt_d == CNTW'(FRAME_WORDS))
                    state_d = FULL;
                else
                    state_d = IDLE;
            end
            if (accept) begin
                load    = 1'b1;
                clip_d  = clip_err | beat_clip;
                lane_d  = '0;
                n_d     = n_eff;
                state_d = (n_eff == '0) ? IDLE : WRITE;
            end
        end
        done_d = (state_q == WRITE) && (state_d == FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            n_q        <= '0;
            word_cnt   <= '0;
            data_q     <= '0;
            clip_err   <= 1'b0;
            done_frame <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            n_q        <= n_d;
            word_cnt   <= word_cnt_d;
            clip_err   <= clip_d;
            done_frame <= done_d;
            if (load)
                data_q <= bus.in_data;
        end
    end

    // Write port decodes straight from registers, so it holds its last value when idle.
    assign bus.ofm_we    = (state_q == WRITE);
    assign bus.ofm_wdata = data_q[lane_q*DW2 +: DW2];

    ofm_addr_gen #(
        .OFM_SIZE_POOLING (OFM_SIZE_POOLING),
        .PLANE            (plane_words(OFM_SIZE_POOLING)),
        .FW               (FW),
        .RW               (RW),
        .LW               (LW),
        .ADDR_WIDTH       (ADDR_WIDTH)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .filter (bus.in_filter),
        .row    (bus.in_row),
        .col    (bus.in_col),
        .lane   (lane_q),
        .addr   (bus.ofm_addr)
    );

endmodule

// File: tb/tb_ofm_writeback.sv
// tb/tb_ofm_writeback.sv - scoreboard bench for the OFM writeback stage
module tb_ofm_writeback;
    import ofm_writeback_pkg::*;

    localparam int SS = 16;
    localparam int DW = 8;
    localparam int P  = 13;
    localparam int NF = 256;
    localparam int AW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic done_frame, clip_err;

    int checks      = 0;
    int failures    = 0;
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int cyc         = 0;
    int last_we_cyc = 0;
    logic [31:0] sb[$];

    ofm_writeback_if #(.SYSTOLIC_SIZE(SS), .DATA_WIDTH(DW), .OFM_SIZE_POOLING(P),
                       .NO_FILTER(NF), .ADDR_WIDTH(AW)) bus ();

    ofm_writeback #(.SYSTOLIC_SIZE(SS), .DATA_WIDTH(DW), .OFM_SIZE_POOLING(P),
                    .NO_FILTER(NF), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .done_frame (done_frame),
        .clip_err   (clip_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Every falling edge goes through here: writes are popped from the scoreboard and compared.
    task automatic tick();
        logic [31:0] exp;
        @(negedge clk);
        cyc++;
        if (rst_n && bus.ofm_we) begin
            wr_cnt++;
            last_we_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0d expected no write", bus.ofm_addr, bus.ofm_wdata);
            end else begin
                exp = sb.pop_front();
                if ({bus.ofm_addr, bus.ofm_wdata} !== exp) begin
                    failures++;
                    $display("FAIL write_word got addr=%0d data=%0d expected addr=%0d data=%0d",
                             bus.ofm_addr, bus.ofm_wdata, exp[31:16], exp[15:0]);
                end
            end
        end
        if (done_frame) done_cnt++;
    endtask

    function automatic void push_beat(input int f, input int r, input int c, input int cnt, input int seed);
        int req, avail, n;
        req   = (cnt < SS) ? cnt : SS;
        avail = (c >= P) ? 0 : P - c;
        n     = (req < avail) ? req : avail;
        if (f >= NF || r >= P) n = 0;
        for (int k = 0; k < n; k++)
            sb.push_back({16'(f * P * P + r * P + c + k), 16'(seed + k)});
    endfunction

    task automatic set_beat(input int f, input int r, input int c, input int cnt, input int seed);
        bus.in_filter = 8'(f);
        bus.in_row    = 4'(r);
        bus.in_col    = 4'(c);
        bus.in_count  = 5'(cnt);
        for (int k = 0; k < SS; k++) bus.in_data[k*16 +: 16] = 16'(seed + k);
        bus.in_valid  = 1'b1;
    endtask

    task automatic drive_beat(input int f, input int r, input int c, input int cnt, input int seed,
                              output bit ok);
        int guard;
        tick();
        set_beat(f, r, c, cnt, seed);
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout in_ready=%0b expected 1 within 100 cycles", bus.in_ready);
            bus.in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        push_beat(f, r, c, cnt, seed);
        ok = 1'b1;
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while ((sb.size() != 0 || bus.ofm_we) && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (sb.size() != 0 || bus.ofm_we) begin
            failures++;
            $display("FAIL drain_%s pending=%0d expected 0", name, sb.size());
        end
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.in_ready, bus.ofm_we, done_frame, clip_err} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b expected 0000", {bus.in_ready, bus.ofm_we, done_frame, clip_err});
        end
        checks++;
        if ({bus.ofm_addr, bus.ofm_wdata} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got %h expected 0", {bus.ofm_addr, bus.ofm_wdata});
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_idle_ready got ready=%0b state=%0d expected ready=1 state=0", bus.in_ready, dut.state_q);
        end
    endtask

    task automatic test_single_beat();
        bit ok;
        int bad;
        bad = 0;
        drive_beat(0, 0, 0, 13, 1, ok);
        for (int k = 0; k < 13; k++) begin
            tick();
            if (!bus.ofm_we) bad++;
            if (bus.in_ready !== (k == 12)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_timing got bad=%0d expected 0", bad);
        end
        wait_drain("single");
    endtask

    task automatic test_addr_math();
        bit ok;
        drive_beat(255, 12, 0, 13, 100, ok);
        tick();
        checks++;
        if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== 16'd43251) begin
            failures++;
            $display("FAIL addr_base got we=%0b addr=%0d expected we=1 addr=43251", bus.ofm_we, bus.ofm_addr);
        end
        wait_drain("addr_math");
    endtask

    task automatic test_clip();
        bit ok;
        int w0;
        w0 = wr_cnt;
        drive_beat(1, 2, 10, 16, 50, ok);
        tick();
        checks++;
        if (clip_err !== 1'b1) begin
            failures++;
            $display("FAIL clip_set got %0b expected 1", clip_err);
        end
        wait_drain("clip");
        checks++;
        if (wr_cnt - w0 != 3) begin
            failures++;
            $display("FAIL clip_count got %0d expected 3", wr_cnt - w0);
        end
        pulse_start();
        checks++;
        if (clip_err !== 1'b0) begin
            failures++;
            $display("FAIL clip_clear got %0b expected 0", clip_err);
        end
        w0 = wr_cnt;
        drive_beat(0, 13, 0, 5, 7, ok);
        tick();
        checks++;
        if (clip_err !== 1'b1 || bus.ofm_we !== 1'b0) begin
            failures++;
            $display("FAIL tag_range got clip=%0b we=%0b expected clip=1 we=0", clip_err, bus.ofm_we);
        end
        wait_drain("tag_range");
        checks++;
        if (wr_cnt != w0) begin
            failures++;
            $display("FAIL tag_range_writes got %0d expected 0", wr_cnt - w0);
        end
        pulse_start();
    endtask

    task automatic test_back_to_back();
        int we_cnt, ready_cnt, ready_at;
        we_cnt = 0;
        ready_cnt = 0;
        ready_at = -1;
        tick();
        set_beat(5, 6, 0, 13, 200);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_ready got %0b expected 1", bus.in_ready);
        end
        @(posedge clk);
        push_beat(5, 6, 0, 13, 200);
        for (int i = 0; i < 26; i++) begin
            tick();
            if (i == 0) set_beat(5, 7, 0, 13, 213);
            if (bus.ofm_we) we_cnt++;
            if (i < 13 && bus.in_ready) begin
                ready_cnt++;
                ready_at = i;
            end
            if (i == 12 && bus.in_ready) push_beat(5, 7, 0, 13, 213);
            if (i == 13) bus.in_valid = 1'b0;
        end
        checks++;
        if (we_cnt != 26) begin
            failures++;
            $display("FAIL b2b_writes got %0d expected 26", we_cnt);
        end
        checks++;
        if (ready_cnt != 1 || ready_at != 12) begin
            failures++;
            $display("FAIL b2b_ready got count=%0d at=%0d expected count=1 at=12", ready_cnt, ready_at);
        end
        wait_drain("b2b");
    endtask

    task automatic test_full_frame();
        bit ok;
        int w0, d0, guard, bad;
        pulse_start();
        w0 = wr_cnt;
        d0 = done_cnt;
        ok = 1'b1;
        for (int f = 0; f < NF && ok; f++)
            for (int r = 0; r < P && ok; r++)
                drive_beat(f, r, 0, 13, f * 13 + r, ok);
        guard = 0;
        while (!done_frame && guard < 50) begin
            tick();
            guard++;
        end
        checks++;
        if (done_frame !== 1'b1) begin
            failures++;
            $display("FAIL done_timeout done_frame=%0b expected 1", done_frame);
        end
        checks++;
        if (cyc != last_we_cyc + 1) begin
            failures++;
            $display("FAIL done_latency got cycle=%0d expected %0d", cyc, last_we_cyc + 1);
        end
        checks++;
        if (wr_cnt - w0 != OFM_WORDS) begin
            failures++;
            $display("FAIL frame_writes got %0d expected %0d", wr_cnt - w0, OFM_WORDS);
        end
        set_beat(0, 0, 0, 13, 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.in_ready || bus.ofm_we) bad++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad != 0 || dut.state_q !== FULL) begin
            failures++;
            $display("FAIL full_hold got bad=%0d state=%0d expected bad=0 state=2", bad, dut.state_q);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL done_pulses got %0d expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_abort();
        bit ok;
        pulse_start();
        checks++;
        if (bus.in_ready !== 1'b1 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL abort_leave_full got ready=%0b state=%0d expected ready=1 state=0", bus.in_ready, dut.state_q);
        end
        drive_beat(3, 4, 0, 13, 300, ok);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (bus.ofm_we !== 1'b1 || bus.ofm_addr !== 16'd564) begin
            failures++;
            $display("FAIL abort_lane5 got we=%0b addr=%0d expected we=1 addr=564", bus.ofm_we, bus.ofm_addr);
        end
        start = 1'b1;
        tick();
        checks++;
        if (bus.ofm_we !== 1'b0 || dut.state_q !== IDLE || dut.word_cnt !== '0) begin
            failures++;
            $display("FAIL abort_state got we=%0b state=%0d cnt=%0d expected 0 0 0", bus.ofm_we, dut.state_q, dut.word_cnt);
        end
        start = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready got %0b expected 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.ofm_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_resume got we=%0b expected 0", bus.ofm_we);
        end
    endtask

    task automatic test_reset_mid_beat();
        bit ok;
        drive_beat(7, 1, 0, 13, 400, ok);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.in_ready, bus.ofm_we, done_frame, clip_err, bus.ofm_addr, bus.ofm_wdata} !== 36'h0) begin
            failures++;
            $display("FAIL reset_mid_beat got %h expected 0",
                     {bus.in_ready, bus.ofm_we, done_frame, clip_err, bus.ofm_addr, bus.ofm_wdata});
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.ofm_we !== 1'b0 || dut.state_q !== IDLE) begin
            failures++;
            $display("FAIL reset_no_resume got we=%0b state=%0d expected 0 0", bus.ofm_we, dut.state_q);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_count  = '0;
        bus.in_filter = '0;
        bus.in_row    = '0;
        bus.in_col    = '0;
        test_reset();
        test_single_beat();
        test_addr_math();
        test_clip();
        test_back_to_back();
        test_full_frame();
        test_abort();
        test_reset_mid_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
